reg_rename_file: RTL and testbench
==================================

# reg_rename_file

Architectural register file with per-register rename tags, between decoder and ROB. Holds committed values of x0–x31 and, per register, the ROB tag of the youngest in-flight writer. Decoder reads source operands (value plus tag) and installs new rename tags. ROB commit writes values and clears tags. A mispredict flush drops all tags.

## Interface
Parameters:
- `XLEN`, default 32: data width.
- `TAG_W`, default 5: rename tag width. Bit 4 set means no rename.
- `NO_RENAME`, default 5'd16: tag value meaning "value in file is current".

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset. Synchronous, active-high.
- `rdy` in 1: global enable. When low, all state holds.
- `flush` in 1: ROB jump_wrong, mispredict recovery.
- `commit_rd` in 6: ROB commit destination. Bit 5 set means no commit (6'b100000 is null).
- `commit_value` in XLEN: committed result.
- `commit_tag` in TAG_W: ROB index of the committing entry.
- `rename_en` in 1: decoder allocates a destination this cycle.
- `rename_rd` in 5: destination register of the issuing instruction.
- `rename_tag` in TAG_W: ROB free tag assigned to it.
- `rs1_idx`, `rs2_idx` in 5: source register indices.
- `rs1_value`, `rs2_value` out XLEN: operand values (combinational).
- `rs1_tag`, `rs2_tag` out TAG_W: pending ROB tag, or NO_RENAME if the value is valid (combinational).

## Operation
- State: `value[32]` (XLEN bits each) and `tag[32]` (TAG_W bits each).
- Reset: every value is 0 and every tag is NO_RENAME. Read outputs therefore show 0 / NO_RENAME.
- x0: reads always return 0 / NO_RENAME. Commits and renames to x0 are ignored.
- Commit, when `rdy` is high, `commit_rd[5]` is 0 and rd != 0:
  - Write `value[rd] <= commit_value`.
  - If `tag[rd] == commit_tag`, set `tag[rd] <= NO_RENAME`. Otherwise the tag is untouched, because a younger writer is pending.
  - A repeated identical commit on consecutive cycles is idempotent. The ROB holds `to_reg_rd` between commits.
- Rename, when `rdy` is high, `rename_en` is high, rd != 0 and `flush` is low:
  - Set `tag[rd] <= rename_tag`.
- Same-register commit and rename in one cycle: the value is written and the rename tag wins (new tag, not NO_RENAME).
- Flush, when `rdy` is high: every tag becomes NO_RENAME.
  - A same-cycle commit value is still written.
  - A same-cycle rename is dropped.
- Read port x, combinational:
  - If the commit is valid, `commit_rd == rs_idx`, rd != 0 and `tag[rs_idx] == commit_tag`: output `commit_value` / NO_RENAME (commit bypass).
  - Otherwise output `value[rs_idx]` / `tag[rs_idx]`.
  - A same-cycle rename is never forwarded to reads. Sources of an instruction see state from before its own rd rename (e.g. `add x5,x5,x1`).

## Timing
- Reads: zero latency, combinational from state plus commit inputs.
- Commit, rename and flush take effect at the next rising edge. The following cycle's reads reflect them.
- `rdy` low: no state change. Reads remain valid.
- Reset takes priority over flush, commit and rename.

## Structure
- Shared `define.v` constants: `NO_RENAME` (5'd16), `REG_NULL` (6'b100000), `DATALEN`, `REGINDEX`, `ROBINDEX`.
- One sub-module, `rf_read_port`, instantiated twice. It contains the index mux and commit-bypass compare.

## Test plan
- Reset, then read x1 and x31: 0 / 16 on both ports.
- Rename x5 with tag 3, next cycle commit x5=0xDEAD with tag 3: during the commit cycle rs1=x5 reads 0xDEAD/16 via bypass; afterwards 0xDEAD/16 from the file.
- Rename x7 with tag 2, then rename x7 with tag 9, then commit x7 with tag 2 and value 0x11: reads give 0x11 / 9 (stale commit keeps the tag).
- Same cycle: rename x4 with tag 6 and rs1=x4 (tag previously 16, value 0x5) reads 0x5/16. Next cycle reads 0x5/6.
- Pending tags on x1, x2, x3, then flush together with commit x2=0x22 and rename x8: all tags 16, x2=0x22, x8 tag remains 16.
- Commit x0=0xFF and rename x0: x0 reads 0/16. With `rdy` low, a commit to x9 has no effect.

Source files
------------

// File: rtl/reg_rename_file_pkg.sv
// Shared constants for the rename-tagged architectural register file.
// Tag value NO_RENAME_TAG marks a register whose file value is current.
// REG_NULL marks a null commit destination from the ROB.
package reg_rename_file_pkg;

  localparam int DATALEN  = 32;
  localparam int REGINDEX = 5;
  localparam int ROBINDEX = 5;
  localparam int NUM_REGS = 32;

  localparam logic [ROBINDEX-1:0] NO_RENAME_TAG = 5'd16;
  localparam logic [REGINDEX:0]   REG_NULL      = 6'b100000;

  // A commit lands only when the null bit is clear and it is not aimed at x0.
  function automatic logic commit_targets_reg(input logic [REGINDEX:0] rd);
    return ((rd & REG_NULL) == '0) && (rd != '0);
  endfunction

endpackage

// File: rtl/reg_rename_file_rf_read_port.sv
// One operand read port: index mux plus commit bypass.
// Purely combinational, zero latency.
// No backpressure; x0 always reads as 0 / NO_RENAME.
module rf_read_port
  import reg_rename_file_pkg::*;
#(
  parameter int XLEN  = DATALEN,
  parameter int TAG_W = ROBINDEX,
  parameter logic [TAG_W-1:0] NO_RENAME = TAG_W'(NO_RENAME_TAG)
) (
  input  logic [REGINDEX-1:0] idx,
  input  logic [XLEN-1:0]     values [NUM_REGS],
  input  logic [TAG_W-1:0]    tags   [NUM_REGS],
  input  logic                commit_ok,
  input  logic [REGINDEX-1:0] commit_idx,
  input  logic [XLEN-1:0]     commit_value,
  input  logic [TAG_W-1:0]    commit_tag,
  output logic [XLEN-1:0]     value,
  output logic [TAG_W-1:0]    tag
);

  logic bypass;

  // A commit that retires the youngest writer of this register is forwarded
  // so the consumer does not wait one extra cycle for the file write.
  always_comb begin
    bypass = commit_ok && (commit_idx == idx) && (tags[idx] == commit_tag);
    value  = values[idx];
    tag    = tags[idx];
    if (idx == '0) begin
      value = '0;
      tag   = NO_RENAME;
    end else if (bypass) begin
      value = commit_value;
      tag   = NO_RENAME;
    end
  end

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register ROB rename tags.
// Reads are combinational; commit/rename/flush land at the next clk edge.
// rdy low freezes all state; reads stay valid.
module reg_rename_file
  import reg_rename_file_pkg::*;
#(
  parameter int XLEN  = DATALEN,
  parameter int TAG_W = ROBINDEX,
  parameter logic [TAG_W-1:0] NO_RENAME = TAG_W'(NO_RENAME_TAG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                flush,
  input  logic [REGINDEX:0]   commit_rd,
  input  logic [XLEN-1:0]     commit_value,
  input  logic [TAG_W-1:0]    commit_tag,
  input  logic                rename_en,
  input  logic [REGINDEX-1:0] rename_rd,
  input  logic [TAG_W-1:0]    rename_tag,
  input  logic [REGINDEX-1:0] rs1_idx,
  input  logic [REGINDEX-1:0] rs2_idx,
  output logic [XLEN-1:0]     rs1_value,
  output logic [XLEN-1:0]     rs2_value,
  output logic [TAG_W-1:0]    rs1_tag,
  output logic [TAG_W-1:0]    rs2_tag
);

  logic [XLEN-1:0]  value_q [NUM_REGS];
  logic [TAG_W-1:0] tag_q   [NUM_REGS];
  logic             commit_ok;
  logic             rename_ok;

  // Qualify the update strobes once; x0 is never written.
  always_comb begin
    commit_ok = rdy && commit_targets_reg(commit_rd);
    rename_ok = rdy && rename_en && !flush && (rename_rd != '0);
  end

  // Per-register update. Tag priority: flush clears everything, then a new
  // rename, then a matching commit releasing the rename. A stale commit
  // (tag mismatch) writes the value but leaves the younger tag in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= NO_RENAME;
      end
    end else if (rdy) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (commit_ok && commit_rd[REGINDEX-1:0] == i[REGINDEX-1:0]) begin
          value_q[i] <= commit_value;
        end
        if (flush) begin
          tag_q[i] <= NO_RENAME;
        end else if (rename_ok && rename_rd == i[REGINDEX-1:0]) begin
          tag_q[i] <= rename_tag;
        end else if (commit_ok && commit_rd[REGINDEX-1:0] == i[REGINDEX-1:0]
                     && tag_q[i] == commit_tag) begin
          tag_q[i] <= NO_RENAME;
        end
      end
    end
  end

  rf_read_port #(
    .XLEN      (XLEN),
    .TAG_W     (TAG_W),
    .NO_RENAME (NO_RENAME)
  ) u_rs1 (
    .idx          (rs1_idx),
    .values       (value_q),
    .tags         (tag_q),
    .commit_ok    (commit_ok),
    .commit_idx   (commit_rd[REGINDEX-1:0]),
    .commit_value (commit_value),
    .commit_tag   (commit_tag),
    .value        (rs1_value),
    .tag          (rs1_tag)
  );

  rf_read_port #(
    .XLEN      (XLEN),
    .TAG_W     (TAG_W),
    .NO_RENAME (NO_RENAME)
  ) u_rs2 (
    .idx          (rs2_idx),
    .values       (value_q),
    .tags         (tag_q),
    .commit_ok    (commit_ok),
    .commit_idx   (commit_rd[REGINDEX-1:0]),
    .commit_value (commit_value),
    .commit_tag   (commit_tag),
    .value        (rs2_value),
    .tag          (rs2_tag)
  );

endmodule

// File: tb/tb_reg_rename_file.sv
// Bench for reg_rename_file: directed vector table, reset-priority sequence,
// then randomized traffic against an array-based reference model.
module tb_reg_rename_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic [5:0]  commit_rd;
  logic [31:0] commit_value;
  logic [4:0]  commit_tag;
  logic        rename_en;
  logic [4:0]  rename_rd;
  logic [4:0]  rename_tag;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [31:0] rs1_value;
  logic [31:0] rs2_value;
  logic [4:0]  rs1_tag;
  logic [4:0]  rs2_tag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_rename_file dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .flush        (flush),
    .commit_rd    (commit_rd),
    .commit_value (commit_value),
    .commit_tag   (commit_tag),
    .rename_en    (rename_en),
    .rename_rd    (rename_rd),
    .rename_tag   (rename_tag),
    .rs1_idx      (rs1_idx),
    .rs2_idx      (rs2_idx),
    .rs1_value    (rs1_value),
    .rs2_value    (rs2_value),
    .rs1_tag      (rs1_tag),
    .rs2_tag      (rs2_tag)
  );

  typedef struct {
    logic        rdy;
    logic        flush;
    logic [5:0]  crd;
    logic [31:0] cval;
    logic [4:0]  ctag;
    logic        ren;
    logic [4:0]  rrd;
    logic [4:0]  rtag;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] e1v;
    logic [4:0]  e1t;
    logic [31:0] e2v;
    logic [4:0]  e2t;
  } vec_t;

  localparam logic [5:0] NUL = 6'b100000;
  localparam logic [4:0] NR  = 5'd16;

  function automatic vec_t v(input logic r, input logic f, input logic [5:0] crd,
                             input logic [31:0] cval, input logic [4:0] ctag,
                             input logic ren, input logic [4:0] rrd, input logic [4:0] rtag,
                             input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [31:0] e1v, input logic [4:0] e1t,
                             input logic [31:0] e2v, input logic [4:0] e2t);
    vec_t x;
    x.rdy = r; x.flush = f; x.crd = crd; x.cval = cval; x.ctag = ctag;
    x.ren = ren; x.rrd = rrd; x.rtag = rtag; x.rs1 = rs1; x.rs2 = rs2;
    x.e1v = e1v; x.e1t = e1t; x.e2v = e2v; x.e2t = e2t;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic [5:0] crd,
                       input logic [31:0] cval, input logic [4:0] ctag,
                       input logic ren, input logic [4:0] rrd, input logic [4:0] rtag,
                       input logic [4:0] s1, input logic [4:0] s2);
    rdy = r; flush = f; commit_rd = crd; commit_value = cval; commit_tag = ctag;
    rename_en = ren; rename_rd = rrd; rename_tag = rtag; rs1_idx = s1; rs2_idx = s2;
  endtask

  // Reference model state
  logic [31:0] m_val [32];
  logic [4:0]  m_tag [32];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_val[i] = '0;
      m_tag[i] = NR;
    end
  endtask

  function automatic logic [36:0] model_read(input logic [4:0] idx);
    if (idx == 0) return {32'd0, NR};
    if (rdy && !commit_rd[5] && commit_rd[4:0] == idx && m_tag[idx] == commit_tag)
      return {commit_value, NR};
    return {m_val[idx], m_tag[idx]};
  endfunction

  task automatic model_clock();
    logic cvalid;
    if (!rdy) return;
    cvalid = !commit_rd[5] && commit_rd[4:0] != 0;
    if (cvalid) begin
      m_val[commit_rd[4:0]] = commit_value;
      if (m_tag[commit_rd[4:0]] == commit_tag) m_tag[commit_rd[4:0]] = NR;
    end
    if (flush) begin
      for (int i = 0; i < 32; i++) m_tag[i] = NR;
    end else if (rename_en && rename_rd != 0) begin
      m_tag[rename_rd] = rename_tag;
    end
  endtask

  vec_t tbl [$];

  initial begin
    logic [36:0] e1;
    logic [36:0] e2;

    // Directed table: each row is driven for one cycle with reads checked
    // before the edge that applies the row's updates.
    tbl.push_back(v(1,0,NUL,0,0,        0,0,0,   1,31,  0,NR,0,NR));
    tbl.push_back(v(1,0,NUL,0,0,        1,5,3,   5,1,   0,NR,0,NR));
    tbl.push_back(v(1,0,6'd5,32'hDEAD,3, 0,0,0,  5,5,   32'hDEAD,NR,32'hDEAD,NR));
    tbl.push_back(v(1,0,NUL,0,0,        0,0,0,   5,0,   32'hDEAD,NR,0,NR));
    tbl.push_back(v(1,0,NUL,0,0,        1,7,2,   7,7,   0,NR,0,NR));
    tbl.push_back(v(1,0,NUL,0,0,        1,7,9,   7,5,   0,5'd2,32'hDEAD,NR));
    tbl.push_back(v(1,0,6'd7,32'h11,2,  0,0,0,   7,7,   0,5'd9,0,5'd9));
    tbl.push_back(v(1,0,NUL,0,0,        0,0,0,   7,5,   32'h11,5'd9,32'hDEAD,NR));
    tbl.push_back(v(1,0,6'd4,32'h5,0,   0,0,0,   4,4,   0,NR,0,NR));
    tbl.push_back(v(1,0,NUL,0,0,        1,4,6,   4,4,   32'h5,NR,32'h5,NR));
    tbl.push_back(v(1,0,NUL,0,0,        1,1,1,   4,1,   32'h5,5'd6,0,NR));
    tbl.push_back(v(1,0,NUL,0,0,        1,2,10,  1,2,   0,5'd1,0,NR));
    tbl.push_back(v(1,0,NUL,0,0,        1,3,11,  1,2,   0,5'd1,0,5'd10));
    tbl.push_back(v(1,1,6'd2,32'h22,10, 1,8,13,  2,3,   32'h22,NR,0,5'd11));
    tbl.push_back(v(1,0,NUL,0,0,        0,0,0,   1,2,   0,NR,32'h22,NR));
    tbl.push_back(v(1,0,NUL,0,0,        0,0,0,   3,8,   0,NR,0,NR));
    tbl.push_back(v(1,0,NUL,0,0,        0,0,0,   4,7,   32'h5,NR,32'h11,NR));
    tbl.push_back(v(1,0,6'd0,32'hFF,0,  1,0,4,   0,0,   0,NR,0,NR));
    tbl.push_back(v(1,0,NUL,0,0,        0,0,0,   0,0,   0,NR,0,NR));
    tbl.push_back(v(1,0,NUL,0,0,        1,7,12,  7,9,   32'h11,NR,0,NR));
    tbl.push_back(v(0,0,6'd9,32'h99,0,  1,9,5,   7,9,   32'h11,5'd12,0,NR));
    tbl.push_back(v(0,1,NUL,0,0,        0,0,0,   9,7,   0,NR,32'h11,5'd12));
    tbl.push_back(v(1,0,NUL,0,0,        0,0,0,   9,7,   0,NR,32'h11,5'd12));
    tbl.push_back(v(1,0,6'd5,32'hBEEF,7, 1,5,8,  5,5,   32'hDEAD,NR,32'hDEAD,NR));
    tbl.push_back(v(1,0,NUL,0,0,        0,0,0,   5,5,   32'hBEEF,5'd8,32'hBEEF,5'd8));
    tbl.push_back(v(1,0,6'd5,32'hCAFE,8, 1,5,14, 5,5,   32'hCAFE,NR,32'hCAFE,NR));
    tbl.push_back(v(1,0,NUL,0,0,        0,0,0,   5,5,   32'hCAFE,5'd14,32'hCAFE,5'd14));
    tbl.push_back(v(1,0,6'd5,32'hCAFE,14,0,0,0,  5,5,   32'hCAFE,NR,32'hCAFE,NR));
    tbl.push_back(v(1,0,6'd5,32'hCAFE,14,0,0,0,  5,5,   32'hCAFE,NR,32'hCAFE,NR));
    tbl.push_back(v(1,0,NUL,0,0,        0,0,0,   5,31,  32'hCAFE,NR,0,NR));

    rst = 1'b1;
    drive(1, 0, NUL, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rdy, tbl[i].flush, tbl[i].crd, tbl[i].cval, tbl[i].ctag,
            tbl[i].ren, tbl[i].rrd, tbl[i].rtag, tbl[i].rs1, tbl[i].rs2);
      #1;
      chk($sformatf("vec%0d rs1_value", i), rs1_value, tbl[i].e1v);
      chk($sformatf("vec%0d rs1_tag", i),   {27'd0, rs1_tag}, {27'd0, tbl[i].e1t});
      chk($sformatf("vec%0d rs2_value", i), rs2_value, tbl[i].e2v);
      chk($sformatf("vec%0d rs2_tag", i),   {27'd0, rs2_tag}, {27'd0, tbl[i].e2t});
      @(negedge clk);
    end

    // Reset wins over a same-cycle rename, commit and flush.
    drive(1, 0, NUL, 0, 0, 1, 6, 3, 6, 6);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 1, 6'd6, 32'h77, 3, 1, 6, 4, 6, 5);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, NUL, 0, 0, 0, 0, 0, 6, 5);
    #1;
    chk("rst_prio x6 value", rs1_value, 32'd0);
    chk("rst_prio x6 tag", {27'd0, rs1_tag}, {27'd0, NR});
    chk("rst_prio x5 value", rs2_value, 32'd0);
    chk("rst_prio x5 tag", {27'd0, rs2_tag}, {27'd0, NR});
    @(negedge clk);

    // Randomized traffic against the model; small tag range forces matches.
    model_reset();
    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 9) != 0),
            ($urandom_range(0, 14) == 0),
            ($urandom_range(0, 2) == 0) ? NUL : 6'($urandom_range(0, 31)),
            $urandom,
            5'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 31)),
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)));
      #1;
      e1 = model_read(rs1_idx);
      e2 = model_read(rs2_idx);
      chk($sformatf("rand%0d rs1", c), {rs1_value}, e1[36:5]);
      chk($sformatf("rand%0d rs1_tag", c), {27'd0, rs1_tag}, {27'd0, e1[4:0]});
      chk($sformatf("rand%0d rs2", c), {rs2_value}, e2[36:5]);
      chk($sformatf("rand%0d rs2_tag", c), {27'd0, rs2_tag}, {27'd0, e2[4:0]});
      model_clock();
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
